// File: rtl/dcache_axi_bridge_pkg.sv
// Shared constants for the data-cache AXI bridge: FSM state encoding, AXI field
// encodings and the line-index width helper.
package dcache_axi_bridge_pkg;

    localparam int WORD = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Bits needed to index a word within a line (LINE_WORDS is a power of two).
    function automatic int line_idx_w(input int words);
        int w;
        w = 0;
        for (int i = 0; i < 30; i++) begin
            if ((1 << i) < words) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// AXI4 master-port bundle between the data-cache bridge (master) and the
// interconnect (slave).
interface dcache_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/dcache_line_assembler.sv
// Refill line register with beat counter. clr only rewinds the counter, so
// words not reached by a short burst keep their previous contents.
module dcache_line_assembler
    import dcache_axi_bridge_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       load,
    input  logic [WORD-1:0]            beat_data,
    output logic                       last_word,
    output logic [WORD*LINE_WORDS-1:0] line
);

    localparam int CNT_W = line_idx_w(LINE_WORDS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WORD-1:0]  words_q [LINE_WORDS];
    logic [WORD-1:0]  words_d [LINE_WORDS];

    always_comb begin
        cnt_d   = cnt_q;
        words_d = words_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            words_d[cnt_q] = beat_data;
            cnt_d          = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            words_q <= '{default: '0};
        end else begin
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

    assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));

    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line[i*WORD +: WORD] = words_q[i];
        end
    end

endmodule

// File: rtl/dcache_axi_bridge.sv
// Data-cache to AXI4 bridge: loads refill a full line with an INCR burst, stores
// write through as one beat. Define DCACHE_BRIDGE_ERR_EN for sticky error capture.
//   state     | meaning
//   IDLE      | waiting for a cache request
//   RD_ADDR   | presenting the line read address
//   RD_DATA   | collecting refill beats
//   WR        | presenting write address and data (independent handshakes)
//   WR_RESP   | waiting for the write response
//   DONE      | one-cycle mem_ready pulse
module dcache_axi_bridge
    import dcache_axi_bridge_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    input  logic                       mem_for_store,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic                       mem_ready,
    output logic [WORD*LINE_WORDS-1:0] mem_rline,
`ifdef DCACHE_BRIDGE_ERR_EN
    output logic                       err_sticky,
    output logic [ADDR_W-1:0]          err_addr,
`endif
    dcache_axi_bridge_if.master        axi
);

    localparam int OFF_W = line_idx_w(LINE_WORDS) + 2;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              asm_clr;
    logic              asm_last;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        asm_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (mem_for_store) begin
                        addr_d    = mem_addr;
                        wdata_d   = mem_wdata;
                        wstrb_d   = mem_wstrb;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WR;
                    end else begin
                        addr_d  = {mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        asm_clr = 1'b1;
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: if (axi.arready) state_d = S_RD_DATA;
            S_RD_DATA: if (axi.rvalid && (axi.rlast || asm_last)) state_d = S_DONE;
            S_WR: begin
                // Each channel may complete first; advance once both have.
                if (axi.awready) aw_done_d = 1'b1;
                if (axi.wready)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: if (axi.bvalid) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    dcache_line_assembler #(.LINE_WORDS(LINE_WORDS)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .load      ((state_q == S_RD_DATA) && axi.rvalid),
        .beat_data (axi.rdata),
        .last_word (asm_last),
        .line      (mem_rline)
    );

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = SIZE_WORD;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = (state_q == S_RD_ADDR);
    assign axi.rready  = (state_q == S_RD_DATA);
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = SIZE_WORD;
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = (state_q == S_WR) && !aw_done_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (state_q == S_WR) && !w_done_q;
    assign axi.bready  = (state_q == S_WR_RESP);
    assign mem_ready   = (state_q == S_DONE);

`ifdef DCACHE_BRIDGE_ERR_EN
    logic              err_sticky_q, err_sticky_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              resp_err;

    always_comb begin
        resp_err     = (axi.rvalid && axi.rready && (axi.rresp != RESP_OKAY)) ||
                       (axi.bvalid && axi.bready && (axi.bresp != RESP_OKAY));
        err_sticky_d = err_sticky_q | resp_err;
        err_addr_d   = err_addr_q;
        if (resp_err && !err_sticky_q) err_addr_d = addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_addr   = err_addr_q;

    logic unused_resp;
    assign unused_resp = ^axi.rid;
`else
    logic unused_resp;
    assign unused_resp = ^{axi.rid, axi.rresp, axi.bresp};
`endif

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge: directed table, reset abort sequence
// and randomized traffic against a line/latency reference model.
module tb_dcache_axi_bridge;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_valid;
    logic          mem_for_store;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [32*LW-1:0] mem_rline;
`ifdef DCACHE_BRIDGE_ERR_EN
    logic          err_sticky;
    logic [31:0]   err_addr;
`endif

    always #5 clk = ~clk;

    dcache_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    dcache_axi_bridge #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_for_store (mem_for_store),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .mem_rline     (mem_rline),
`ifdef DCACHE_BRIDGE_ERR_EN
        .err_sticky    (err_sticky),
        .err_addr      (err_addr),
`endif
        .axi           (axi)
    );

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rbase;
        int          ar_dly;
        int          gap;
        int          nbeats;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          err_beat;
        bit          berr;
        int          rst_after;
        int          exp_lat;
        logic [31:0] exp_axaddr;
    } txn_t;

    int checks = 0;
    int errors = 0;

    // Reference model: line contents as an array, sticky error state.
    logic [31:0] mline [LW];
    bit          m_err;
    logic [31:0] m_err_addr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_line();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < LW; i++) r[i*32 +: 32] = mline[i];
        return r;
    endfunction

    function automatic int model_lat(input txn_t t);
        int m;
        if (t.st) begin
            m = (t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly;
            return (m + 1) + (t.b_dly + 1) + 1;
        end
        return (t.ar_dly + 1) + t.nbeats * (t.gap + 1) + 1;
    endfunction

    function automatic logic [31:0] model_axaddr(input txn_t t);
        if (t.st) return t.addr;
        return t.addr & ~32'(LW * 4 - 1);
    endfunction

    function automatic txn_t mk_load(input logic [31:0] addr, input logic [31:0] rbase,
                                     input int ar, input int gap, input int nb, input int eb,
                                     input int lat, input logic [31:0] ax);
        txn_t t;
        t.st = 1'b0; t.addr = addr; t.wdata = '0; t.wstrb = '0; t.rbase = rbase;
        t.ar_dly = ar; t.gap = gap; t.nbeats = nb; t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0;
        t.err_beat = eb; t.berr = 1'b0; t.rst_after = -1; t.exp_lat = lat; t.exp_axaddr = ax;
        return t;
    endfunction

    function automatic txn_t mk_store(input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [3:0] wstrb, input int aw, input int w,
                                      input int b, input int lat);
        txn_t t;
        t.st = 1'b1; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.rbase = '0;
        t.ar_dly = 0; t.gap = 0; t.nbeats = 0; t.aw_dly = aw; t.w_dly = w; t.b_dly = b;
        t.err_beat = -1; t.berr = 1'b0; t.rst_after = -1; t.exp_lat = lat; t.exp_axaddr = addr;
        return t;
    endfunction

    task automatic clear_axi();
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LW; i++) mline[i] = '0;
        m_err = 1'b0;
        m_err_addr = '0;
    endtask

    task automatic run_txn(input txn_t t);
        int cyc, beat, gcnt, arc, awc, wc, bc;
        int ar_extra, aw_extra, w_extra, rready_bad;
        bit ar_hs, aw_hs, w_hs, done;
        cyc = 0; beat = 0; gcnt = 0; arc = 0; awc = 0; wc = 0; bc = 0;
        ar_extra = 0; aw_extra = 0; w_extra = 0; rready_bad = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; done = 0;
        mem_valid = 1'b1; mem_for_store = t.st; mem_addr = t.addr;
        mem_wdata = t.wdata; mem_wstrb = t.wstrb;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            clear_axi();
            if (t.rst_after >= 0 && beat == t.rst_after) begin
                rst = 1'b1; mem_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("reset_mid_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
                                         axi.bready, mem_ready}, '0);
                chk("reset_mid_rline", mem_rline, '0);
                model_reset();
                return;
            end
            if (mem_ready) begin
                chk("latency", cyc, t.exp_lat);
                done = 1;
            end else begin
                if (ar_hs && beat < t.nbeats) begin
                    if (!axi.rready) rready_bad++;
                    else if (gcnt >= t.gap) begin
                        axi.rvalid = 1'b1;
                        axi.rdata  = t.rbase + beat;
                        axi.rlast  = (beat == t.nbeats - 1);
                        axi.rresp  = (beat == t.err_beat) ? 2'b10 : 2'b00;
                        mline[beat] = t.rbase + beat;
                        if (beat == t.err_beat && !m_err) begin
                            m_err = 1'b1; m_err_addr = t.exp_axaddr;
                        end
                        beat++; gcnt = 0;
                    end else gcnt++;
                end
                if (axi.arvalid) begin
                    if (ar_hs) ar_extra++;
                    else begin
                        if (arc == 0) begin
                            chk("araddr", axi.araddr, t.exp_axaddr);
                            chk("ar_fields", {axi.arid, axi.arlen, axi.arsize, axi.arburst},
                                {4'd0, 8'(LW - 1), 3'b010, 2'b01});
                        end
                        if (arc >= t.ar_dly) begin axi.arready = 1'b1; ar_hs = 1; end
                        arc++;
                    end
                end
                if (axi.bready) begin
                    if (bc >= t.b_dly) begin
                        axi.bvalid = 1'b1;
                        axi.bresp  = t.berr ? 2'b10 : 2'b00;
                        if (t.berr && !m_err) begin m_err = 1'b1; m_err_addr = t.exp_axaddr; end
                    end
                    bc++;
                end
                if (axi.awvalid) begin
                    if (aw_hs) aw_extra++;
                    else begin
                        if (awc == 0) begin
                            chk("awaddr", axi.awaddr, t.exp_axaddr);
                            chk("aw_fields", {axi.awid, axi.awlen, axi.awsize}, {4'd0, 8'd0, 3'b010});
                        end
                        if (awc >= t.aw_dly) begin axi.awready = 1'b1; aw_hs = 1; end
                        awc++;
                    end
                end
                if (axi.wvalid) begin
                    if (w_hs) w_extra++;
                    else begin
                        if (wc == 0) chk("w_fields", {axi.wdata, axi.wstrb, axi.wlast},
                                         {t.wdata, t.wstrb, 1'b1});
                        if (wc >= t.w_dly) begin axi.wready = 1'b1; w_hs = 1; end
                        wc++;
                    end
                end
            end
        end
        mem_valid = 1'b0;
        clear_axi();
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: no mem_ready within %0d cycles (addr %0h)", cyc, t.addr);
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            model_reset();
            return;
        end
        chk("rline", mem_rline, model_line());
        if (!t.st) begin
            chk("rready_held", rready_bad, 0);
            chk("arvalid_drop", ar_extra, 0);
        end else begin
            chk("awvalid_drop", aw_extra, 0);
            chk("wvalid_drop", w_extra, 0);
        end
`ifdef DCACHE_BRIDGE_ERR_EN
        chk("err_sticky", err_sticky, m_err);
        chk("err_addr", err_addr, m_err_addr);
`endif
        @(posedge clk); #1;
        chk("ready_pulse_once", mem_ready, 1'b0);
        @(posedge clk); #1;
    endtask

    txn_t tbl [8];

    initial begin
        mem_valid = 1'b0; mem_for_store = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        axi.rid = 4'd0; axi.rdata = '0;
        clear_axi();
        model_reset();

        tbl[0] = mk_load (32'h1C00_0014, 32'h0000_00A0, 0, 0, 4, -1, 6,  32'h1C00_0010);
        tbl[1] = mk_load (32'h1C00_0020, 32'h0000_00B0, 3, 2, 4, -1, 17, 32'h1C00_0020);
        tbl[2] = mk_store(32'h1C00_0008, 32'hDEAD_BEEF, 4'b0011, 0, 3, 0, 6);
        tbl[3] = mk_store(32'h1C00_0100, 32'h1234_5678, 4'b1111, 0, 0, 5, 8);
        tbl[4] = mk_store(32'h1C00_0FFC, 32'hCAFE_F00D, 4'b1000, 2, 0, 1, 6);
        tbl[5] = mk_load (32'h1C00_003C, 32'h0000_00C0, 1, 1, 2, -1, 7,  32'h1C00_0030);
        tbl[6] = mk_load (32'h2000_0044, 32'h0000_00D0, 0, 0, 4, 1,  6,  32'h2000_0040);
        tbl[7] = mk_store(32'h2000_0050, 32'h0000_0000, 4'b1111, 0, 0, 0, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
                             axi.bready, mem_ready}, '0);
        chk("reset_rline", mem_rline, '0);
`ifdef DCACHE_BRIDGE_ERR_EN
        chk("reset_err", {err_sticky, err_addr}, '0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
            if (i == 0) chk("refill_line_A", mem_rline, 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0);
        end

        begin
            txn_t t;
            t = mk_load(32'h1C00_0080, 32'h0000_00E0, 0, 0, 4, -1, 6, 32'h1C00_0080);
            t.rst_after = 2;
            run_txn(t);
            run_txn(mk_load(32'h1C00_0200, 32'h5A5A_0000, 0, 0, 1, -1, 3, 32'h1C00_0200));
            chk("post_reset_word0", mem_rline[31:0], 32'h5A5A_0000);
            chk("post_reset_upper", mem_rline[127:32], '0);
        end

        for (int i = 0; i < 40; i++) begin
            txn_t t;
            t.st       = ($urandom_range(0, 1) == 1);
            t.addr     = $urandom;
            t.wdata    = $urandom;
            t.wstrb    = 4'($urandom_range(0, 15));
            t.rbase    = $urandom;
            t.ar_dly   = $urandom_range(0, 3);
            t.gap      = $urandom_range(0, 2);
            t.nbeats   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LW)) : LW;
            t.aw_dly   = $urandom_range(0, 3);
            t.w_dly    = $urandom_range(0, 3);
            t.b_dly    = $urandom_range(0, 4);
            t.err_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            t.berr     = ($urandom_range(0, 4) == 0);
            t.rst_after  = -1;
            t.exp_lat    = model_lat(t);
            t.exp_axaddr = model_axaddr(t);
            run_txn(t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_axi_bridge.md
Name: dcache_axi_bridge

Overview:
- Downstream neighbour of the data-cache control FSM. Consumes its memory request (valid, store flag, address, data) and drives an AXI4 master port.
- Loads become an INCR burst that refills one full cache line. Stores become a single-beat write-through.
- Returns a one-cycle ready pulse to the cache. For loads, the assembled line is presented with that pulse.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, AXI data width; must be 32
- LINE_WORDS, 4, words per cache line; power of two, 2..16
- AXI_ID, 0, constant value driven on arid/awid

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  cache request; held high until mem_ready
- mem_for_store  in  1  1 = store write-through, 0 = line refill
- mem_addr  in  ADDR_W  request byte address
- mem_wdata  in  32  store data
- mem_wstrb  in  4  store byte enables
- mem_ready  out  1  one-cycle completion pulse
- mem_rline  out  32*LINE_WORDS  refill line; word i is at bits [32i+31:32i]
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/ADDR_W/8/3/2/1  AXI read address channel
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data channel
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/ADDR_W/8/3/2/1  AXI write address channel
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data channel
- wready  in  1
- bresp/bvalid  in  2/1  AXI write response channel
- bready  out  1

Behaviour:
- Reset values: all valid/ready outputs 0; mem_rline 0; beat counter 0; state IDLE.
- Reset mid-transaction returns to IDLE immediately. No AXI completion is awaited; the system resets the interconnect together with this block.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE:
  - mem_valid & !mem_for_store: capture the address aligned down to the line boundary (low log2(LINE_WORDS)+2 bits cleared). Go to RD_ADDR.
  - mem_valid & mem_for_store: capture the address, data and strobe unmodified. Go to WR.
  - The request is sampled only in IDLE. Request inputs are ignored in all other states.
- RD_ADDR: arvalid=1, arlen=LINE_WORDS-1, arsize=2, arburst=INCR. On arvalid & arready, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - Each rvalid beat writes rdata into word[cnt], then cnt++.
  - On the beat with rlast, or the beat where cnt==LINE_WORDS-1, go to DONE.
  - An rlast arriving early ends the burst; unfilled words keep their stale value.
- WR:
  - awvalid=1 and wvalid=1 are raised together. wlast=1, awlen=0, awsize=2.
  - The aw and w handshakes complete independently, tracked by aw_done/w_done flags. Each valid drops in the cycle after its own handshake.
  - Both handshakes may complete in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, go to DONE.
- DONE: mem_ready=1 for exactly one cycle. Go to IDLE.
  - The cache drops mem_valid after that pulse, so a new request can start no earlier than 2 cycles after DONE.
- mem_rline is stable from DONE until the next refill's first beat.
- Minimum latency, with zero-wait AXI:
  - Load: 1 (RD_ADDR) + LINE_WORDS + 1 (DONE) cycles after acceptance.
  - Store: 1 + 1 + 1 cycles.
- A nonzero rresp or bresp does not change the flow in the base build.
- rid is ignored. Only one transaction is ever outstanding.

Optional Feature:
- Macro DCACHE_BRIDGE_ERR_EN.
- When defined, two extra outputs are added:
  - err_sticky (1): set by any rresp!=0 beat or by bresp!=0; cleared only by rst.
  - err_addr (ADDR_W): holds the captured request address of the first erroring transaction; later errors do not overwrite it.
- When undefined, the ports and registers are absent and responses are ignored.

Decomposition:
- Shared package/header CPU_Parameter.vh, which already carries WORD, holds:
  - the state encoding constants;
  - AXI constants: BURST_INCR=2'b01, SIZE_WORD=3'b010, RESP_OKAY=2'b00;
  - the LINE_WORDS log2 helper.
- One natural sub-module, dcache_line_assembler: beat counter plus line register, with load-enable and clear inputs.

Test Plan:
- Refill, zero-wait. Request mem_addr=0x1C00_0014. Expect araddr=0x1C00_0010, arlen=3. Beats rdata 0xA0..0xA3 produce mem_rline={A3,A2,A1,A0}, with mem_ready exactly 6 cycles after acceptance.
- Refill, stalls. Hold arready low for 3 cycles and rvalid low between beats. Expect the line to be correct, mem_ready to pulse once, and rready to stay high throughout RD_DATA.
- Store with skewed handshakes. Request addr=0x1C00_0008, wdata=0xDEADBEEF, wstrb=4'b0011. Give awready at cycle 1 and wready at cycle 4. Expect awvalid to drop after cycle 1, and mem_ready to pulse only after bvalid.
- Same-cycle aw/w handshake, with bvalid delayed 5 cycles. Expect a single WR_RESP wait and mem_ready 1 cycle after bvalid.
- Reset during RD_DATA after 2 beats. Expect all valids to be 0 the next cycle, state IDLE, and the next refill to start at word 0.
- Under DCACHE_BRIDGE_ERR_EN: give rresp=2'b10 on beat 1. Expect err_sticky=1 and err_addr=line address. A following clean store leaves both unchanged.
